cook_controller: RTL and testbench

Sequencing controller for the microwave magnetron. It accepts digit entry and start/stop/clear buttons, and holds the mm:ss cook time as four BCD digits. It counts that time down on a 1 Hz enable and drives the magnetron enable only while cooking with the door closed. It sits between the debounced front-panel inputs and the magnetron/display blocks, and replaces ad-hoc latch set/reset with an explicit state machine.

---
 rtl/microwave_pkg.sv | 26 ++
 rtl/bcd_mmss_counter.sv | 82 ++++++++
 rtl/cook_controller.sv | 161 ++++++++++++++++
 tb/tb_cook_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and defaults for the microwave cook controller.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int DONE_TICKS_DEFAULT      = 3;
    localparam int QUICK_SECS_TENS_DEFAULT = 3;

    function automatic logic bcd_is_digit(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // One BCD digit down; 'wrap' is the value taken when borrowing out of zero.
    function automatic bcd_t bcd_dec(input bcd_t d, input bcd_t wrap);
        return (d == 4'd0) ? wrap : (d - 4'd1);
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit mm:ss BCD register with clear, load, decrement and shift-in.
module bcd_mmss_counter
    import microwave_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic load_i,
    input  bcd_t load_secs_tens_i,
    input  logic dec_i,
    input  logic shift_i,
    input  bcd_t digit_i,
    output bcd_t mins_tens_o,
    output bcd_t mins_ones_o,
    output bcd_t secs_tens_o,
    output bcd_t secs_ones_o,
    output logic is_zero_o,
    output logic is_one_o
);

    bcd_t mt_q, mo_q, st_q, so_q;
    bcd_t mt_d, mo_d, st_d, so_d;
    logic brw_so_s, brw_st_s, brw_mo_s;

    assign brw_so_s  = (so_q == 4'd0);
    assign brw_st_s  = brw_so_s && (st_q == 4'd0);
    assign brw_mo_s  = brw_st_s && (mo_q == 4'd0);
    assign is_zero_o = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign is_one_o  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);

    // Next digit values; seconds-tens wraps to 5, other digits to 9.
    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clr_i) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = 4'd0;
            so_d = 4'd0;
        end else if (load_i) begin
            mt_d = 4'd0;
            mo_d = 4'd0;
            st_d = load_secs_tens_i;
            so_d = 4'd0;
        end else if (dec_i && !is_zero_o) begin
            so_d = bcd_dec(so_q, 4'd9);
            st_d = brw_so_s ? bcd_dec(st_q, 4'd5) : st_q;
            mo_d = brw_st_s ? bcd_dec(mo_q, 4'd9) : mo_q;
            mt_d = brw_mo_s ? bcd_dec(mt_q, 4'd9) : mt_q;
        end else if (shift_i) begin
            mt_d = mo_q;
            mo_d = st_q;
            st_d = so_q;
            so_d = digit_i;
        end else begin
            so_d = so_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mt_q <= 4'd0;
            mo_q <= 4'd0;
            st_q <= 4'd0;
            so_q <= 4'd0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign mins_tens_o = mt_q;
    assign mins_ones_o = mo_q;
    assign secs_tens_o = st_q;
    assign secs_ones_o = so_q;

endmodule

// File: rtl/cook_controller.sv
// Microwave cook sequencing FSM: digit entry, countdown, pause and done beep.
module cook_controller
    import microwave_pkg::*;
#(
    parameter int DONE_TICKS      = DONE_TICKS_DEFAULT,
    parameter int QUICK_SECS_TENS = QUICK_SECS_TENS_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state,
    output logic [3:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones
);

    localparam int CNT_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               start_q, stop_q, beep_q;
    logic               start_ev_s, stop_ev_s, key_ok_s;
    logic               clr_s, load_s, dec_s, shift_s;
    logic               is_zero_s, is_one_s;

    assign start_ev_s = start_q && !startn;
    assign stop_ev_s  = stop_q && !stopn;
    assign key_ok_s   = key_valid && bcd_is_digit(key_digit);

    // Next state and counter commands; clear overrides every state.
    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        clr_s      = 1'b0;
        load_s     = 1'b0;
        dec_s      = 1'b0;
        shift_s    = 1'b0;
        if (!clearn) begin
            state_d    = ST_IDLE;
            clr_s      = 1'b1;
            done_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stop_ev_s) begin
                        clr_s = 1'b1;
                    end else if (start_ev_s && door_closed) begin
                        load_s  = 1'b1;
                        state_d = ST_COOKING;
                    end else if (key_ok_s) begin
                        shift_s = 1'b1;
                        state_d = ST_ENTRY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ENTRY: begin
                    if (stop_ev_s) begin
                        clr_s   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (start_ev_s) begin
                        state_d = (door_closed && !is_zero_s) ? ST_COOKING : ST_ENTRY;
                    end else if (key_ok_s) begin
                        shift_s = 1'b1;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
                ST_COOKING: begin
                    if (stop_ev_s || !door_closed) begin
                        state_d = ST_PAUSED;
                    end else if (tick_1hz) begin
                        dec_s      = 1'b1;
                        state_d    = is_one_s ? ST_DONE : ST_COOKING;
                        done_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_COOKING;
                    end
                end
                ST_PAUSED: begin
                    if (stop_ev_s) begin
                        clr_s   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (start_ev_s && door_closed) begin
                        state_d = ST_COOKING;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    if (stop_ev_s) begin
                        state_d    = ST_IDLE;
                        done_cnt_d = {CNT_W{1'b0}};
                    end else if (tick_1hz) begin
                        if (done_cnt_q == CNT_W'(DONE_TICKS - 1)) begin
                            state_d    = ST_IDLE;
                            done_cnt_d = {CNT_W{1'b0}};
                        end else begin
                            done_cnt_d = done_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    clr_s   = 1'b1;
                end
            endcase
        end
    end

    // State, done counter, button history and beep registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            done_cnt_q <= {CNT_W{1'b0}};
            start_q    <= 1'b1;
            stop_q     <= 1'b1;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_cnt_q <= done_cnt_d;
            start_q    <= startn;
            stop_q     <= stopn;
            beep_q     <= (state_d == ST_DONE);
        end
    end

    bcd_mmss_counter u_counter (
        .clk              (clk),
        .resetn           (resetn),
        .clr_i            (clr_s),
        .load_i           (load_s),
        .load_secs_tens_i (bcd_t'(QUICK_SECS_TENS)),
        .dec_i            (dec_s),
        .shift_i          (shift_s),
        .digit_i          (key_digit),
        .mins_tens_o      (mins_tens),
        .mins_ones_o      (mins_ones),
        .secs_tens_o      (secs_tens),
        .secs_ones_o      (secs_ones),
        .is_zero_o        (is_zero_s),
        .is_one_o         (is_one_s)
    );

    // Door term stays combinational so opening the door cuts power immediately.
    assign mag_on = (state_q == ST_COOKING) && door_closed;
    assign beep   = beep_q;
    assign state  = state_q;

endmodule

// File: tb/tb_cook_controller.sv
// Self-checking bench for cook_controller: directed scenarios plus a randomized run against a seconds-based model.
module tb_cook_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       clearn = 1'b1;
    logic       door_closed = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       mag_on, beep;
    logic [2:0] state;
    logic [3:0] mins_tens, mins_ones, secs_tens, secs_ones;
    logic [15:0] digits;

    int checks = 0;
    int errors = 0;

    localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    // Reference model: time kept as minutes and seconds integers.
    int m_st;
    int m_min;
    int m_sec;
    int m_beeps;
    bit m_start_prev;
    bit m_stop_prev;

    cook_controller dut (
        .clk         (clk),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .tick_1hz    (tick_1hz),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .mag_on      (mag_on),
        .beep        (beep),
        .state       (state),
        .mins_tens   (mins_tens),
        .mins_ones   (mins_ones),
        .secs_tens   (secs_tens),
        .secs_ones   (secs_ones)
    );

    assign digits = {mins_tens, mins_ones, secs_tens, secs_ones};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_min = 0; m_sec = 0; m_beeps = 0;
        m_start_prev = 1'b1; m_stop_prev = 1'b1;
    endtask

    task automatic model_shift(input int d);
        int all;
        all = (m_min * 100 + m_sec) % 1000;
        all = all * 10 + d;
        m_min = all / 100;
        m_sec = all % 100;
    endtask

    task automatic model_step();
        bit sev, pev, kok;
        sev = m_stop_prev && !stopn;
        pev = m_start_prev && !startn;
        m_stop_prev = stopn;
        m_start_prev = startn;
        kok = key_valid && (key_digit < 4'd10);
        if (!clearn) begin
            m_st = S_IDLE; m_min = 0; m_sec = 0;
        end else begin
            case (m_st)
                S_IDLE:
                    if (sev) begin m_min = 0; m_sec = 0; end
                    else if (pev && door_closed) begin m_min = 0; m_sec = 30; m_st = S_COOK; end
                    else if (kok) begin model_shift(int'(key_digit)); m_st = S_ENTRY; end
                S_ENTRY:
                    if (sev) begin m_min = 0; m_sec = 0; m_st = S_IDLE; end
                    else if (pev) begin
                        if (door_closed && (m_min + m_sec) != 0) m_st = S_COOK;
                    end else if (kok) model_shift(int'(key_digit));
                S_COOK:
                    if (sev || !door_closed) m_st = S_PAUSE;
                    else if (tick_1hz) begin
                        if (m_sec > 0) m_sec = m_sec - 1;
                        else begin m_min = m_min - 1; m_sec = 59; end
                        if (m_min == 0 && m_sec == 0) begin m_st = S_DONE; m_beeps = 0; end
                    end
                S_PAUSE:
                    if (sev) begin m_min = 0; m_sec = 0; m_st = S_IDLE; end
                    else if (pev && door_closed) m_st = S_COOK;
                S_DONE:
                    if (sev) m_st = S_IDLE;
                    else if (tick_1hz) begin
                        m_beeps = m_beeps + 1;
                        if (m_beeps == 3) m_st = S_IDLE;
                    end
                default: m_st = S_IDLE;
            endcase
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        #1;
    endtask

    task automatic key_in(input int d);
        key_valid = 1'b1; key_digit = 4'(d);
        clk_step();
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0; clk_step(); startn = 1'b1; clk_step();
    endtask

    task automatic press_stop();
        stopn = 1'b0; clk_step(); stopn = 1'b1; clk_step();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1; clk_step(); tick_1hz = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clk_step(); clk_step();
        @(negedge clk); resetn = 1'b1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h exp 0000", digits); end
        checks++; if ({mag_on, beep} !== 2'b00) begin errors++; $display("FAIL reset_outputs got %b exp 00", {mag_on, beep}); end
    endtask

    task automatic test_entry_cook();
        key_in(1); key_in(2); key_in(3);
        checks++; if (digits !== 16'h0123 || state !== 3'd1) begin errors++; $display("FAIL entry_digits got %h/%0d exp 0123/1", digits, state); end
        startn = 1'b0;
        checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL pre_start_mag got %b exp 0", mag_on); end
        clk_step();
        startn = 1'b1;
        checks++; if (state !== 3'd2 || mag_on !== 1'b1) begin errors++; $display("FAIL start_latency got %0d/%b exp 2/1", state, mag_on); end
        tick_n(82);
        checks++; if (digits !== 16'h0001 || state !== 3'd2) begin errors++; $display("FAIL cook_82 got %h/%0d exp 0001/2", digits, state); end
        tick_n(1);
        checks++; if (state !== 3'd4 || beep !== 1'b1 || mag_on !== 1'b0 || digits !== 16'h0000) begin
            errors++; $display("FAIL done_entry got st %0d beep %b mag %b dig %h exp 4 1 0 0000", state, beep, mag_on, digits); end
        tick_n(2);
        checks++; if (state !== 3'd4 || beep !== 1'b1) begin errors++; $display("FAIL done_hold got %0d/%b exp 4/1", state, beep); end
        tick_n(1);
        checks++; if (state !== 3'd0 || beep !== 1'b0) begin errors++; $display("FAIL done_exit got %0d/%b exp 0/0", state, beep); end
    endtask

    task automatic test_quick_start();
        startn = 1'b0; clk_step(); startn = 1'b1;
        checks++; if (digits !== 16'h0030 || state !== 3'd2) begin errors++; $display("FAIL quick_load got %h/%0d exp 0030/2", digits, state); end
        clk_step();
        tick_n(29);
        checks++; if (digits !== 16'h0001 || state !== 3'd2) begin errors++; $display("FAIL quick_29 got %h/%0d exp 0001/2", digits, state); end
        tick_n(1);
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL quick_done got %0d exp 4", state); end
        press_stop();
        checks++; if (state !== 3'd0 || beep !== 1'b0) begin errors++; $display("FAIL done_stop got %0d/%b exp 0/0", state, beep); end
    endtask

    task automatic test_borrow();
        key_in(1); key_in(0); key_in(0);
        press_start();
        tick_n(1);
        checks++; if (digits !== 16'h0059) begin errors++; $display("FAIL borrow_min got %h exp 0059", digits); end
        press_stop(); press_stop();
        checks++; if (digits !== 16'h0000 || state !== 3'd0) begin errors++; $display("FAIL paused_stop got %h/%0d exp 0000/0", digits, state); end
        key_in(7); key_in(5);
        press_start();
        tick_n(15);
        checks++; if (digits !== 16'h0060) begin errors++; $display("FAIL tens75_15 got %h exp 0060", digits); end
        tick_n(1);
        checks++; if (digits !== 16'h0059) begin errors++; $display("FAIL tens75_16 got %h exp 0059", digits); end
        tick_n(58);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL tens75_74 got %0d exp 2", state); end
        tick_n(1);
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL tens75_done got %0d exp 4", state); end
        press_stop();
    endtask

    task automatic test_door();
        key_in(1); key_in(0);
        press_start();
        door_closed = 1'b0;
        #1;
        checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL door_comb got %b exp 0", mag_on); end
        clk_step();
        tick_n(3);
        checks++; if (state !== 3'd3 || digits !== 16'h0010) begin errors++; $display("FAIL door_pause got %0d/%h exp 3/0010", state, digits); end
        press_start();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL open_start got %0d exp 3", state); end
        door_closed = 1'b1;
        press_start();
        checks++; if (state !== 3'd2 || mag_on !== 1'b1 || digits !== 16'h0010) begin
            errors++; $display("FAIL resume got %0d/%b/%h exp 2/1/0010", state, mag_on, digits); end
        press_stop(); press_stop();
    endtask

    task automatic test_tick_stop();
        key_in(5);
        press_start();
        tick_1hz = 1'b1; stopn = 1'b0;
        clk_step();
        tick_1hz = 1'b0; stopn = 1'b1;
        checks++; if (state !== 3'd3 || digits !== 16'h0005) begin errors++; $display("FAIL tick_stop got %0d/%h exp 3/0005", state, digits); end
        clk_step();
        press_stop();
        checks++; if (state !== 3'd0 || digits !== 16'h0000) begin errors++; $display("FAIL second_stop got %0d/%h exp 0/0000", state, digits); end
    endtask

    task automatic test_reset_clear_mid();
        key_in(2); key_in(0);
        press_start();
        tick_n(1);
        #2 resetn = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || mag_on !== 1'b0 || digits !== 16'h0000) begin
            errors++; $display("FAIL async_reset got %0d/%b/%h exp 0/0/0000", state, mag_on, digits); end
        model_reset();
        @(negedge clk); resetn = 1'b1;
        key_in(2); key_in(0);
        press_start();
        clearn = 1'b0;
        clk_step();
        checks++; if (state !== 3'd0 || mag_on !== 1'b0 || digits !== 16'h0000) begin
            errors++; $display("FAIL clear_mid got %0d/%b/%h exp 0/0/0000", state, mag_on, digits); end
        key_in(4);
        checks++; if (state !== 3'd0 || digits !== 16'h0000) begin errors++; $display("FAIL clear_blocks got %0d/%h exp 0/0000", state, digits); end
        clearn = 1'b1;
        clk_step();
    endtask

    task automatic test_ignored_start();
        key_in(0);
        press_start();
        checks++; if (state !== 3'd1 || mag_on !== 1'b0) begin errors++; $display("FAIL zero_start got %0d/%b exp 1/0", state, mag_on); end
        key_in(5);
        door_closed = 1'b0;
        press_start();
        checks++; if (state !== 3'd1 || digits !== 16'h0005) begin errors++; $display("FAIL open_entry got %0d/%h exp 1/0005", state, digits); end
        press_stop();
        press_start();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL open_quick got %0d exp 0", state); end
        door_closed = 1'b1;
        key_in(11);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL bad_digit got %0d exp 0", state); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clearn      = ($urandom_range(0, 63) != 0);
            startn      = ($urandom_range(0, 5) != 0);
            stopn       = ($urandom_range(0, 24) != 0);
            door_closed = ($urandom_range(0, 11) != 0);
            tick_1hz    = ($urandom_range(0, 2) == 0);
            key_valid   = ($urandom_range(0, 3) == 0);
            key_digit   = 4'($urandom_range(0, 15));
            if (key_valid && $urandom_range(0, 1) == 0) key_digit = 4'($urandom_range(0, 2));
            clk_step();
            checks++; if (int'(state) != m_st) begin errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", i, state, m_st); end
            checks++; if (digits !== model_digits()) begin errors++; $display("FAIL rnd_digits cyc %0d got %h exp %h", i, digits, model_digits()); end
            checks++; if (mag_on !== (m_st == S_COOK && door_closed)) begin errors++; $display("FAIL rnd_mag cyc %0d got %b", i, mag_on); end
            checks++; if (beep !== (m_st == S_DONE)) begin errors++; $display("FAIL rnd_beep cyc %0d got %b", i, beep); end
        end
        clearn = 1'b1; startn = 1'b1; stopn = 1'b1; tick_1hz = 1'b0; key_valid = 1'b0; door_closed = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_entry_cook();
        test_quick_start();
        test_borrow();
        test_door();
        test_tick_stop();
        test_reset_clear_mid();
        test_ignored_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
